vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Timing master for the video path. Divides the 100 MHz system clock to a 25 MHz pixel rate and produces the raster scan for 640x480@60.
- Drives x, y and video_on into the graphics and text renderers, and hsync/vsync to the VGA connector.
- Also issues single-cycle pixel, line and frame ticks, so game logic can advance exactly once per frame.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 4, system clocks per pixel; legal values 2..16
- SYNC_POL, 0, sync active level: 0 = active-low, 1 = active-high

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- enable  in  1  when 0, freezes the divider and counters; outputs hold
- x  out  10  current pixel column, 0..H_TOTAL-1
- y  out  10  current line, 0..V_TOTAL-1
- video_on  out  1  high when x<H_DISPLAY and y<V_DISPLAY
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- p_tick  out  1  one-clk pulse; the counters advance on the next edge
- line_tick  out  1  one-clk pulse, coincident with p_tick when x=H_TOTAL-1
- frame_tick  out  1  one-clk pulse, coincident with p_tick when x=H_TOTAL-1 and y=V_TOTAL-1

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800)
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (default 525)
  - Both must be ≤1024; checked at elaboration.
- Divider:
  - Counter div counts 0..CLK_DIV-1, wraps, and increments on every clk while enable=1.
  - p_tick = enable && (div==CLK_DIV-1).
  - Result: p_tick has period CLK_DIV clks and duty 1/CLK_DIV.
- Horizontal counter: on a clk with p_tick=1, x increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - y increments only on a clk where p_tick=1 and x=H_TOTAL-1.
  - At V_TOTAL-1 it wraps to 0 on that same edge.
- x and y are registers. They are stable for exactly CLK_DIV clks per pixel.
- Sync and blank:
  - hsync, vsync and video_on are registered, computed from the next-state counts so they change on the same edge as x/y. No combinational glitches.
  - hsync active iff H_DISPLAY+H_FRONT ≤ x ≤ H_DISPLAY+H_FRONT+H_SYNC-1 (default 656..751).
  - vsync active iff V_DISPLAY+V_FRONT ≤ y ≤ V_DISPLAY+V_FRONT+V_SYNC-1 (default 490..491).
  - Active level = SYNC_POL; inactive level = ~SYNC_POL.
- Ticks:
  - line_tick and frame_tick are combinational from registered state, gated by p_tick.
  - Each is high for exactly one clk per line or frame.
- Reset values: div=0, x=0, y=0, video_on=1, hsync=vsync=~SYNC_POL, p_tick=line_tick=frame_tick=0.
- First p_tick after reset release occurs on the CLK_DIV-th clk edge.
- Reset mid-frame: all state returns to the reset values immediately (asynchronously). The next frame starts cleanly at (0,0) with no partial sync pulse.
- enable=0:
  - div, x, y and the sync/video_on registers hold.
  - All ticks are 0.
  - Resuming continues from the held div value with no skipped or duplicated pixel.
- Frame period at defaults: 800*525*4 = 1,680,000 clks, i.e. 59.52 Hz at 100 MHz.
- Downstream contract: consumers that must act once per frame use frame_tick, not a decode of x/y. A decode of x/y repeats for CLK_DIV clks.

Test Plan:
- Reset held 10 clks, then released with enable=1 -> x=0, y=0, hsync=vsync=1, video_on=1; first p_tick on clk 4; x=1 after clk 4.
- Run one line -> x wraps 799→0 once; line_tick pulses exactly once per 3200 clks; y increments only on that edge.
- Horizontal sync check -> hsync=0 exactly for x=656..751 (384 clks per line); video_on=0 for x≥640; video_on=1 again at x=0 of a visible line.
- Full frame -> vsync=0 for y=490..491 (6400 clks); frame_tick period 1,680,000 clks with exactly one pulse; y wraps 524→0 on that tick.
- Assert reset at x=700, y=490 (mid hsync and vsync) -> on the same edge, hsync=vsync=1, x=y=0; next frame_tick arrives 1,680,000 clks after release.
- enable=0 for 37 clks at x=100 -> x, y and sync outputs hold with no ticks; after re-enable, the x sequence continues 101, 102… and total frame length grows by exactly 37 clks. Repeat with SYNC_POL=1 -> sync levels inverted.

Source files
------------

// File: rtl/vga_sync_gen.sv
// Raster timing generator: divides the system clock to the pixel rate and
// produces x/y counters, registered sync/blank, and single-clk pixel/line/frame ticks.
module vga_sync_gen #(
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter int   CLK_DIV   = 4,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       p_tick,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_div
            $error("vga_sync_gen: CLK_DIV must be in 2..16");
        end
    endgenerate

    logic [DIV_W-1:0] div;
    logic [9:0]       x_next;
    logic [9:0]       y_next;

    assign p_tick     = enable && (div == DIV_LAST);
    assign line_tick  = p_tick && (x == H_LAST);
    assign frame_tick = line_tick && (y == V_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        x_next = x;
        y_next = y;
        if (p_tick) begin
            x_next = (x == H_LAST) ? 10'd0 : x + 10'd1;
        end
        if (line_tick) begin
            y_next = (y == V_LAST) ? 10'd0 : y + 10'd1;
        end
    end

    // Sync and blank are computed from the next counts so they switch on the same edge as x/y.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div      <= '0;
            x        <= '0;
            y        <= '0;
            video_on <= 1'b1;
            hsync    <= ~SYNC_POL;
            vsync    <= ~SYNC_POL;
        end else if (enable) begin
            div      <= p_tick ? '0 : div + DIV_W'(1);
            x        <= x_next;
            y        <= y_next;
            video_on <= (x_next < H_VIS) && (y_next < V_VIS);
            hsync    <= (x_next >= HS_START && x_next <= HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync    <= (y_next >= VS_START && y_next <= VS_END) ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a shrunken raster (15x8 pixels, CLK_DIV=4,
// 480 clks per frame); a second instance uses active-high sync.
module tb_vga_sync_gen;

    localparam int HD = 8, HF = 2, HS = 3, HB = 2;   // H_TOTAL 15, hsync x=10..12
    localparam int VD = 4, VF = 1, VS = 2, VB = 1;   // V_TOTAL 8,  vsync y=5..6
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [9:0] x, y, x2, y2;
    logic       video_on, hsync, vsync, p_tick, line_tick, frame_tick;
    logic       video_on2, hsync2, vsync2, p_tick2, line_tick2, frame_tick2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(DIV), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .x(x), .y(y),
        .video_on(video_on), .hsync(hsync), .vsync(vsync),
        .p_tick(p_tick), .line_tick(line_tick), .frame_tick(frame_tick)
    );

    vga_sync_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(DIV), .SYNC_POL(1'b1)
    ) dut_pos (
        .clk(clk), .reset(reset), .enable(enable), .x(x2), .y(y2),
        .video_on(video_on2), .hsync(hsync2), .vsync(vsync2),
        .p_tick(p_tick2), .line_tick(line_tick2), .frame_tick(frame_tick2)
    );

    typedef struct {
        logic rst;
        logic en;
        int   ex;
        logic pt;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Outputs are sampled 1 ns after the active edge; inputs change right after sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    initial begin
        int k, lim, found;
        int n_pt, n_lt, n_ft, n_hs_lo, n_vs_lo, n_von, n_hs2_hi, n_vs2_hi;
        int first_lt, first_ft, second_ft, y_at_479;
        int bad_x, bad_y, bad_region, bad_hold;
        int px, py, ppt, plt, exp_hs, exp_vs, exp_von, last_x, nx1, nx2;

        // Expected x and p_tick after each edge, from reset through a short enable gap.
        vecs[0]  = '{1'b1, 1'b1, 0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 2, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 2, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 2, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 2, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 2, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 2, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 3, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 3, 1'b0};

        for (int i = 0; i < 18; i++) begin
            reset  = vecs[i].rst;
            enable = vecs[i].en;
            step();
            check($sformatf("vec%0d_x", i), int'(x), vecs[i].ex);
            check($sformatf("vec%0d_ptick", i), int'(p_tick), int'(vecs[i].pt));
            check($sformatf("vec%0d_y", i), int'(y), 0);
            check($sformatf("vec%0d_lft", i), int'({line_tick, frame_tick}), 0);
            check($sformatf("vec%0d_sync", i), int'({video_on, hsync, vsync}), 3'b111);
            check($sformatf("vec%0d_sync_pos", i), int'({hsync2, vsync2}), 2'b00);
        end

        // Full frame and a half from a clean reset.
        do_reset();
        n_pt = 0; n_lt = 0; n_ft = 0; n_hs_lo = 0; n_vs_lo = 0; n_von = 0;
        n_hs2_hi = 0; n_vs2_hi = 0; first_lt = -1; first_ft = -1; second_ft = -1;
        y_at_479 = -1; bad_x = 0; bad_y = 0; bad_region = 0;
        px = 0; py = 0; ppt = 0; plt = 0;
        for (k = 1; k <= 960; k++) begin
            step();
            if (int'(x) != px && (ppt == 0 || int'(x) != (px + 1) % 15)) bad_x++;
            if (int'(y) != py && (plt == 0 || int'(y) != (py + 1) % 8)) bad_y++;
            if (int'(y) != py && int'(x) != 0) bad_y++;
            exp_hs  = (x >= 10 && x <= 12) ? 0 : 1;
            exp_vs  = (y >= 5 && y <= 6) ? 0 : 1;
            exp_von = (x < 8 && y < 4) ? 1 : 0;
            if (int'(hsync) != exp_hs || int'(vsync) != exp_vs || int'(video_on) != exp_von)
                bad_region++;
            if (line_tick && first_lt < 0) first_lt = k;
            if (frame_tick) begin
                if (first_ft < 0) first_ft = k;
                else if (second_ft < 0) second_ft = k;
            end
            if (k <= 480) begin
                n_pt += int'(p_tick);
                n_lt += int'(line_tick);
                n_ft += int'(frame_tick);
                n_hs_lo += int'(!hsync);
                n_vs_lo += int'(!vsync);
                n_von += int'(video_on);
                n_hs2_hi += int'(hsync2);
                n_vs2_hi += int'(vsync2);
            end
            if (k == 479) y_at_479 = int'(y);
            if (k == 480) begin
                check("frame_wrap_x", int'(x), 0);
                check("frame_wrap_y", int'(y), 0);
            end
            px = int'(x); py = int'(y); ppt = int'(p_tick); plt = int'(line_tick);
        end
        check("frame_p_ticks", n_pt, 120);
        check("frame_line_ticks", n_lt, 8);
        check("frame_frame_ticks", n_ft, 1);
        check("frame_hsync_low_clks", n_hs_lo, 96);
        check("frame_vsync_low_clks", n_vs_lo, 120);
        check("frame_video_on_clks", n_von, 128);
        check("frame_pos_hsync_high_clks", n_hs2_hi, 96);
        check("frame_pos_vsync_high_clks", n_vs2_hi, 120);
        check("first_line_tick_edge", first_lt, 59);
        check("first_frame_tick_edge", first_ft, 479);
        check("frame_tick_period", second_ft - first_ft, 480);
        check("y_before_wrap", y_at_479, 7);
        check("x_step_errors", bad_x, 0);
        check("y_step_errors", bad_y, 0);
        check("sync_region_errors", bad_region, 0);

        // Reset asserted in the middle of both sync pulses.
        do_reset();
        found = 0;
        for (lim = 0; lim < 1000 && !found; lim++) begin
            step();
            if (x == 10'd11 && y == 10'd5) found = 1;
        end
        check("midreset_reached", found, 1);
        check("midreset_pre_sync", int'({hsync, vsync}), 2'b00);
        reset = 1'b1;
        #1;
        check("midreset_xy", int'({x, y}), 0);
        check("midreset_sync", int'({video_on, hsync, vsync}), 3'b111);
        check("midreset_sync_pos", int'({hsync2, vsync2}), 2'b00);
        check("midreset_ticks", int'({p_tick, line_tick, frame_tick}), 0);
        step();
        step();
        reset = 1'b0;
        first_ft = -1;
        for (k = 1; k <= 1000 && first_ft < 0; k++) begin
            step();
            if (frame_tick) first_ft = k;
        end
        check("midreset_next_frame_tick", first_ft, 479);

        // Enable dropped for 37 clks at x=5.
        do_reset();
        found = 0;
        for (k = 1; k <= 200 && !found; k++) begin
            step();
            if (x == 10'd5) found = k;
        end
        check("pause_reached_edge", found, 20);
        enable = 1'b0;
        bad_hold = 0;
        for (int i = 0; i < 37; i++) begin
            step();
            if (x != 10'd5 || y != 10'd0 || {video_on, hsync, vsync} != 3'b111 ||
                {p_tick, line_tick, frame_tick} != 3'b000)
                bad_hold++;
        end
        check("pause_hold_errors", bad_hold, 0);
        enable = 1'b1;
        k = found + 37;
        last_x = 5; nx1 = -1; nx2 = -1; first_ft = -1;
        while (k < 1200 && first_ft < 0) begin
            step();
            k++;
            if (int'(x) != last_x) begin
                if (nx1 < 0) nx1 = int'(x);
                else if (nx2 < 0) nx2 = int'(x);
                last_x = int'(x);
            end
            if (frame_tick) first_ft = k;
        end
        check("resume_x_first", nx1, 6);
        check("resume_x_second", nx2, 7);
        check("pause_frame_tick_edge", first_ft, 516);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
